// File: rtl/pixel_capture_sequencer_if.sv
// pixel_capture_sequencer_if: camera timing/byte inputs, queue-full flags and pixel write outputs of the capture sequencer
interface pixel_capture_sequencer_if;
  logic vsync;
  logic href;
  logic pix_vld;
  logic [7:0] din;
  logic Rful;
  logic Gful;
  logic Bful;
  logic [11:0] pshdta;
  logic Wrtcmplt;
  logic frame_done;
  logic [7:0] drop_cnt;
  logic busy;
  modport master (
    output vsync, href, pix_vld, din, Rful, Gful, Bful,
    input pshdta, Wrtcmplt, frame_done, drop_cnt, busy
  );
  modport slave (
    input vsync, href, pix_vld, din, Rful, Gful, Bful,
    output pshdta, Wrtcmplt, frame_done, drop_cnt, busy
  );
endinterface

// File: rtl/pixel_capture_sequencer.sv
// pixel_capture_sequencer: picks three lines per frame from vsync/href timing and packs camera byte pairs into RGB444 queue writes
module pixel_capture_sequencer #(
  parameter logic [7:0] LINE_A = 8'h20,
  parameter logic [7:0] LINE_B = 8'h80,
  parameter logic [7:0] LINE_C = 8'hF0,
  parameter int PIX_PER_LINE = 64
) (
  input logic clk,
  input logic res,
  pixel_capture_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SYNC, WAIT_LINE, CAPTURE, LINE_END} state_t;
  state_t state, state_nxt;
  logic vs_q, hr_q, wrapped, phase, fd_nxt;
  logic [7:0] line_cnt, pix_cnt, cap_line;
  logic [3:0] r;
  logic vs_rise, vs_fall, hr_rise, hr_fall, sel, take, full, start;
  assign vs_rise = bus.vsync & ~vs_q;
  assign vs_fall = ~bus.vsync & vs_q;
  assign hr_rise = bus.href & ~hr_q;
  assign hr_fall = ~bus.href & hr_q;
  assign sel = ~wrapped & (line_cnt == LINE_A | line_cnt == LINE_B | line_cnt == LINE_C);
  assign take = state == CAPTURE & bus.pix_vld & phase;
  assign full = bus.Rful | bus.Gful | bus.Bful;
  assign start = state == WAIT_LINE & state_nxt == CAPTURE;
  assign bus.busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    fd_nxt = 1'b0;
    case (state)
      IDLE: state_nxt = bus.vsync ? SYNC : IDLE;
      SYNC: state_nxt = vs_fall ? WAIT_LINE : SYNC;
      WAIT_LINE: state_nxt = hr_rise & sel ? CAPTURE : WAIT_LINE;
      CAPTURE: state_nxt = hr_fall | (take & pix_cnt == 8'(PIX_PER_LINE - 1)) ? LINE_END : CAPTURE;
      LINE_END: begin
        fd_nxt = cap_line == LINE_C;
        state_nxt = fd_nxt ? IDLE : WAIT_LINE;
      end
      default: state_nxt = IDLE;
    endcase
    // a new frame starting mid-sequence abandons the current one without frame_done
    if (vs_rise) begin
      state_nxt = SYNC;
      fd_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      wrapped <= 1'b0;
      phase <= 1'b0;
      line_cnt <= 8'd0;
      pix_cnt <= 8'd0;
      cap_line <= 8'd0;
      r <= 4'd0;
      bus.pshdta <= 12'd0;
      bus.Wrtcmplt <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.drop_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      vs_q <= bus.vsync;
      hr_q <= bus.href;
      bus.frame_done <= fd_nxt;
      bus.Wrtcmplt <= take & ~full;
      if (take & ~full) bus.pshdta <= {r, bus.din};
      if (take & full & bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
      if (vs_rise) begin
        line_cnt <= 8'd0;
        wrapped <= 1'b0;
      end else if (hr_fall) begin
        line_cnt <= line_cnt + 8'd1;
        if (line_cnt == 8'hFF) wrapped <= 1'b1;
      end
      if (start) begin
        pix_cnt <= 8'd0;
        phase <= 1'b0;
        cap_line <= line_cnt;
      end else if (state == CAPTURE & bus.pix_vld) begin
        phase <= ~phase;
        if (!phase) r <= bus.din[3:0];
        else pix_cnt <= pix_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_pixel_capture_sequencer.sv
// tb_pixel_capture_sequencer: frame-level vector table plus a pixel scoreboard checked on every queue write
module tb_pixel_capture_sequencer;
  logic clk, res;
  pixel_capture_sequencer_if bus();
  pixel_capture_sequencer dut (.clk(clk), .res(res), .bus(bus));
  typedef struct {
    bit long_lines;
    int cut_line;
    int cut_n;
    bit cut_abort;
    int full_line;
    int flo;
    int fhi;
    logic [2:0] fmask;
    int exp_wr;
    int exp_fd;
    int exp_drop;
    int exp_busy;
  } vec_t;
  vec_t vecs[7];
  logic [11:0] exp_q[$];
  int total = 0, bad = 0, wr_cnt = 0, fd_cnt = 0, wr_at_fd = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!res) begin
      if (bus.Wrtcmplt) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 32'(bus.pshdta), -1);
        else check("pshdta", 32'(bus.pshdta), 32'(exp_q.pop_front()));
      end
      if (bus.frame_done) begin
        fd_cnt++;
        wr_at_fd = wr_cnt;
      end
    end
  end
  // mode 0: normal line end, 1: vsync abort with href drop, 2: leave href high
  task automatic send_line(input int idx, input int nb, input logic [2:0] fm, input int flo, input int fhi, input int mode);
    logic [3:0] r4;
    bit s;
    s = idx == 'h20 || idx == 'h80 || idx == 'hF0;
    r4 = 4'd0;
    bus.href = 1'b1;
    tick();
    tick();
    for (int b = 0; b < nb; b++) begin
      bit f;
      f = b / 2 >= flo && b / 2 <= fhi && fm != 3'b000;
      bus.din = 8'(b);
      bus.pix_vld = 1'b1;
      {bus.Rful, bus.Gful, bus.Bful} = f ? fm : 3'b000;
      if (b % 2 == 0) r4 = bus.din[3:0];
      else if (s && b / 2 < 64 && !f) exp_q.push_back({r4, bus.din});
      tick();
    end
    bus.pix_vld = 1'b0;
    {bus.Rful, bus.Gful, bus.Bful} = 3'b000;
    if (mode == 2) return;
    if (mode == 1) bus.vsync = 1'b1;
    bus.href = 1'b0;
    tick();
    tick();
  endtask
  task automatic run_frame(input vec_t v);
    bus.vsync = 1'b1;
    repeat (3) tick();
    bus.vsync = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 256; i++) begin
      bit s;
      int nb, lo, hi, md;
      s = i == 'h20 || i == 'h80 || i == 'hF0;
      nb = (s || v.long_lines) ? 128 : 2;
      md = 0;
      if (i == v.cut_line) begin
        nb = v.cut_n;
        md = v.cut_abort ? 1 : 0;
      end
      lo = (i == v.full_line || v.full_line == 256) ? v.flo : 1000;
      hi = (i == v.full_line || v.full_line == 256) ? v.fhi : -1;
      send_line(i, nb, v.fmask, lo, hi, md);
      if (md == 1) break;
    end
    tick();
    tick();
  endtask
  initial begin
    vecs[0] = '{1'b1, -1, 0, 1'b0, -1, 0, 0, 3'b000, 192, 1, 0, 0};
    vecs[1] = '{1'b0, -1, 0, 1'b0, 'h80, 10, 14, 3'b100, 187, 1, 5, 0};
    vecs[2] = '{1'b0, 'h20, 21, 1'b0, -1, 0, 0, 3'b000, 138, 1, 5, 0};
    vecs[3] = '{1'b0, 'h80, 10, 1'b1, -1, 0, 0, 3'b000, 69, 0, 5, 1};
    vecs[4] = '{1'b0, -1, 0, 1'b0, -1, 0, 0, 3'b000, 192, 1, 5, 0};
    vecs[5] = '{1'b0, -1, 0, 1'b0, 256, 0, 1000, 3'b001, 0, 1, 197, 0};
    vecs[6] = '{1'b0, -1, 0, 1'b0, 256, 0, 1000, 3'b010, 0, 1, 255, 0};
    res = 1'b1;
    bus.vsync = 1'b0;
    bus.href = 1'b0;
    bus.pix_vld = 1'b0;
    bus.din = 8'd0;
    {bus.Rful, bus.Gful, bus.Bful} = 3'b000;
    tick();
    tick();
    res = 1'b0;
    tick();
    bus.vsync = 1'b1;
    repeat (3) tick();
    bus.vsync = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 'h20; i++) send_line(i, 2, 3'b000, 1000, -1, 0);
    send_line('h20, 5, 3'b000, 1000, -1, 2);
    check("pre_reset_writes", wr_cnt, 2);
    #3;
    res = 1'b1;
    #1;
    check("rst_pshdta", 32'(bus.pshdta), 0);
    check("rst_wrtcmplt", 32'(bus.Wrtcmplt), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    tick();
    bus.href = 1'b0;
    tick();
    res = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    fd_cnt = 0;
    repeat (6) tick();
    check("post_rst_writes", wr_cnt, 0);
    check("post_rst_busy", 32'(bus.busy), 0);
    for (int k = 0; k < 7; k++) begin
      wr_cnt = 0;
      fd_cnt = 0;
      wr_at_fd = -1;
      run_frame(vecs[k]);
      check($sformatf("row%0d_writes", k), wr_cnt, vecs[k].exp_wr);
      check($sformatf("row%0d_frame_done", k), fd_cnt, vecs[k].exp_fd);
      if (vecs[k].exp_fd == 1) check($sformatf("row%0d_writes_before_fd", k), wr_at_fd, vecs[k].exp_wr);
      check($sformatf("row%0d_drop_cnt", k), 32'(bus.drop_cnt), vecs[k].exp_drop);
      check($sformatf("row%0d_busy", k), 32'(bus.busy), vecs[k].exp_busy);
      check($sformatf("row%0d_sb_left", k), exp_q.size(), 0);
      exp_q.delete();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
